// File: rtl/masked_sbox_addr_stage.sv
// Address/valid staging ahead of the per-lane masked S-box BRAMs.
// Each lane registers its two share bytes, with the lane's fresh mask bits
// on top, into the port-A/B addresses. A valid/mask delay line sized to the
// BRAM read latency lines up out_valid/rnd_out with DOA/DOB. Every register
// shares the BRAM enable, so the whole stage freezes along with the BRAM.

// One lane: shares stay in separate registers and are never mixed.
module masked_sbox_addr_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       EN,
    input  logic [7:0] s0,
    input  logic [7:0] s1,
    input  logic [1:0] rnd,
    output logic [9:0] addra,
    output logic [9:0] addrb
);

    // Addresses load on every enabled cycle; in_valid only qualifies use.
    always_ff @(posedge clk) begin
        if (rst) begin
            addra <= '0;
            addrb <= '0;
        end else if (EN) begin
            addra <= {rnd, s0};
            addrb <= {rnd, s1};
        end
    end

endmodule

module masked_sbox_addr_stage #(
    parameter int LANES    = 4,
    parameter int BRAM_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EN,
    input  logic                  in_valid,
    input  logic [8*LANES-1:0]    s0,
    input  logic [8*LANES-1:0]    s1,
    input  logic [2*LANES-1:0]    rnd,
    output logic [10*LANES-1:0]   ADDRA,
    output logic [10*LANES-1:0]   ADDRB,
    output logic                  out_valid,
    output logic [2*LANES-1:0]    rnd_out,
    output logic                  ready,
    output logic [CNT_W-1:0]      beat_cnt
);

    localparam int FW = $clog2(BRAM_LAT + 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t                            state;
    logic [FW-1:0]                     fill_cnt;
    logic [BRAM_LAT:0]                 vld_pipe;
    logic [BRAM_LAT:0][2*LANES-1:0]    rnd_pipe;

    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            masked_sbox_addr_lane u_lane (
                .clk   (clk),
                .rst   (rst),
                .EN    (EN),
                .s0    (s0[8*l +: 8]),
                .s1    (s1[8*l +: 8]),
                .rnd   (rnd[2*l +: 2]),
                .addra (ADDRA[10*l +: 10]),
                .addrb (ADDRB[10*l +: 10])
            );
        end
    endgenerate

    // Valid/mask delay line; the final register makes out_valid coincide with BRAM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            rnd_pipe  <= '0;
            out_valid <= 1'b0;
            rnd_out   <= '0;
        end else if (EN) begin
            vld_pipe    <= {vld_pipe[BRAM_LAT-1:0], in_valid};
            rnd_pipe[0] <= rnd;
            for (int k = 1; k <= BRAM_LAT; k++) rnd_pipe[k] <= rnd_pipe[k-1];
            // Stale BRAM output during fill is never flagged.
            out_valid <= vld_pipe[BRAM_LAT] && (state == RUN);
            rnd_out   <= rnd_pipe[BRAM_LAT];
        end
    end

    // Fill FSM: count enabled edges until the BRAM pipe holds real data, then stay in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            fill_cnt <= '0;
            ready    <= 1'b0;
        end else if (EN) begin
            case (state)
                FILL: begin
                    if (fill_cnt == FW'(BRAM_LAT)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                RUN:     state <= RUN;
                default: state <= FILL;
            endcase
        end
    end

    // Saturating count of emitted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (EN && out_valid && (beat_cnt != {CNT_W{1'b1}})) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_masked_sbox_addr_stage.sv
// Bench for masked_sbox_addr_stage: scoreboard of expected beats keyed by the
// enabled edge they should appear on, plus a behavioural BRAM fed by the DUT
// addresses whose output must match the data expected from the stimulus.
module tb_masked_sbox_addr_stage;

    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        EN = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] s0 = '0, s1 = '0;
    logic [7:0]  rnd = '0;
    logic [39:0] ADDRA, ADDRB, ADDRA4, ADDRB4;
    logic        out_valid, ready, out_valid4, ready4;
    logic [7:0]  rnd_out, rnd_out4;
    logic [15:0] beat_cnt;
    logic [3:0]  beat_cnt4;

    masked_sbox_addr_stage #(.LANES(4), .BRAM_LAT(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .EN(EN), .in_valid(in_valid), .s0(s0), .s1(s1), .rnd(rnd),
        .ADDRA(ADDRA), .ADDRB(ADDRB), .out_valid(out_valid), .rnd_out(rnd_out),
        .ready(ready), .beat_cnt(beat_cnt));

    masked_sbox_addr_stage #(.LANES(4), .BRAM_LAT(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .EN(EN), .in_valid(in_valid), .s0(s0), .s1(s1), .rnd(rnd),
        .ADDRA(ADDRA4), .ADDRB(ADDRB4), .out_valid(out_valid4), .rnd_out(rnd_out4),
        .ready(ready4), .beat_cnt(beat_cnt4));

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [7:0]  r;
        logic [31:0] da;
        logic [31:0] db;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;
    int   en_cnt = 0, exp_bc = 0;
    bit   last_ov = 1'b0;
    logic [39:0] exp_a = '0, exp_b = '0;
    logic [39:0] lat_a = '0, lat_b = '0;
    logic [31:0] rd_a = '0, rd_b = '0, do_a = '0, do_b = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Arbitrary fixed table standing in for the masked S-box contents.
    function automatic logic [7:0] tbl(input logic [9:0] a);
        logic [7:0] m;
        m = a[7:0] * 8'd29;
        return m ^ {a[9:8], a[9:8], a[9:8], a[9:8]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] lookup(input logic [39:0] addr);
        logic [31:0] d;
        for (int i = 0; i < LANES; i++) d[8*i +: 8] = tbl(addr[10*i +: 10]);
        return d;
    endfunction

    function automatic logic [39:0] cat(input logic [31:0] s, input logic [7:0] r);
        logic [39:0] a;
        for (int i = 0; i < LANES; i++) a[10*i +: 10] = {r[2*i +: 2], s[8*i +: 8]};
        return a;
    endfunction

    // One clock: drive, take the edge, update models, check everything.
    task automatic tick(input bit en, input bit rs, input bit vin,
                        input logic [31:0] a, input logic [31:0] b, input logic [7:0] r);
        logic [39:0] pre_a, pre_b;
        bit          eov;
        exp_t        e;
        pre_a = ADDRA; pre_b = ADDRB;
        EN = en; rst = rs; in_valid = vin; s0 = a; s1 = b; rnd = r;
        @(posedge clk); #1;
        if (en) begin
            do_a = rd_a; rd_a = lookup(lat_a); lat_a = pre_a;
            do_b = rd_b; rd_b = lookup(lat_b); lat_b = pre_b;
        end
        if (rs) begin
            q.delete(); en_cnt = 0; exp_bc = 0; eov = 1'b0;
            exp_a = '0; exp_b = '0;
        end else if (en) begin
            en_cnt++;
            if (last_ov) exp_bc++;
            exp_a = cat(a, r); exp_b = cat(b, r);
            eov = (q.size() > 0) && (q[0].due == en_cnt);
            if (eov) begin
                e = q.pop_front();
                chk("rnd_out", 64'(rnd_out), 64'(e.r));
                chk("doa", 64'(do_a), 64'(e.da));
                chk("dob", 64'(do_b), 64'(e.db));
            end
            if (vin) q.push_back('{due: en_cnt + 3, r: r,
                                   da: lookup(cat(a, r)), db: lookup(cat(b, r))});
        end else begin
            eov = last_ov;
        end
        last_ov = eov;
        chk("out_valid", 64'(out_valid), 64'(eov));
        chk("out_valid4", 64'(out_valid4), 64'(eov));
        chk("ready", 64'(ready), 64'(en_cnt >= 3));
        chk("ready4", 64'(ready4), 64'(en_cnt >= 3));
        chk("addra", 64'(ADDRA), 64'(exp_a));
        chk("addrb", 64'(ADDRB), 64'(exp_b));
        chk("beat_cnt", 64'(beat_cnt), 64'(exp_bc));
        chk("beat_cnt4", 64'(beat_cnt4), 64'((exp_bc > 15) ? 15 : exp_bc));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, $urandom, $urandom, 8'($urandom));
    endtask

    initial begin
        // 1: reset, then fill
        tick(1, 1, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        chk("rst_rdy", 64'(ready), 64'd0);
        chk("rst_addr", 64'(ADDRA), 64'd0);
        idle(4);

        // 2: single directed beat
        tick(1, 0, 1, {24'h112233, 8'hA5}, {24'h445566, 8'h3C}, 8'b0110_0110);
        chk("t2_addra", 64'(ADDRA[9:0]), 64'h2A5);
        chk("t2_addrb", 64'(ADDRB[9:0]), 64'h23C);
        idle(2);
        chk("t2_ov_pre", 64'(out_valid), 64'd0);
        idle(1);
        chk("t2_ov", 64'(out_valid), 64'd1);
        chk("t2_rnd", 64'(rnd_out[1:0]), 64'h2);
        idle(3);

        // 3: ten back-to-back beats
        for (int i = 0; i < 10; i++) tick(1, 0, 1, $urandom, $urandom, 8'($urandom));
        idle(5);
        chk("t3_bc", 64'(beat_cnt), 64'd11);

        // 4: beat in flight, enable dropped for 5 cycles
        tick(1, 0, 1, 32'hDEADBEEF, 32'hCAFEF00D, 8'h9C);
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 1, $urandom, $urandom, 8'($urandom));
        chk("t4_frozen", 64'(ADDRA), 64'(cat(32'h0, 8'h0)));
        idle(5);

        // 5: reset with two beats in flight, also reset with EN low
        tick(1, 0, 1, $urandom, $urandom, 8'($urandom));
        tick(1, 0, 1, $urandom, $urandom, 8'($urandom));
        tick(1, 1, 0, 0, 0, 0);
        idle(2);
        tick(1, 0, 1, $urandom, $urandom, 8'($urandom));
        tick(0, 1, 1, $urandom, $urandom, 8'($urandom));
        chk("t5_rdy", 64'(ready), 64'd0);
        idle(6);

        // 6: saturation of the narrow counter, then random traffic
        for (int i = 0; i < 20; i++) tick(1, 0, 1, $urandom, $urandom, 8'($urandom));
        for (int i = 0; i < 60; i++)
            tick($urandom_range(0, 4) != 0, 0, $urandom_range(0, 3) != 0,
                 $urandom, $urandom, 8'($urandom));
        idle(6);
        chk("t6_sat", 64'(beat_cnt4), 64'hF);
        chk("t6_q_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
